// File: rtl/ascii_operand_loader_if.sv
// Handshake bundle for the ASCII operand loader.
// master: character source + pair sink; slave: the loader.
interface ascii_operand_loader_if #(
  parameter int OP_W = 10
);
  logic [7:0]      char_in;
  logic            char_valid;
  logic            char_ready;
  logic [OP_W-1:0] op_a;
  logic [OP_W-1:0] op_b;
  logic            ops_valid;
  logic            ops_ready;
  logic            err;

  modport master (
    output char_in, char_valid, ops_ready,
    input  char_ready, op_a, op_b, ops_valid, err
  );

  modport slave (
    input  char_in, char_valid, ops_ready,
    output char_ready, op_a, op_b, ops_valid, err
  );
endinterface

// File: rtl/ascii_operand_loader.sv
// Parses "<digits>+<digits>=" from a char stream into two binary operands.
// Ports: clk, rst (async high), bus (slave: char in / operand pair out / err).
// Optional macro ASCII_SPACE_SKIP_EN: spaces are consumed and ignored.
module ascii_operand_loader #(
  parameter int DIGITS = 3,
  parameter int OP_W   = 10
) (
  input  logic clk,
  input  logic rst,
  ascii_operand_loader_if.slave bus
);
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] DMAX = CW'(DIGITS);

  typedef enum logic [1:0] {
    GET_A,
    GET_B,
    DONE
  } state_t;

  state_t          state, state_n;
  logic [OP_W-1:0] acc_a, acc_a_n;
  logic [OP_W-1:0] acc_b, acc_b_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            err_q, err_n;

  logic            accept;
  logic            is_digit, is_plus, is_eq;
  logic [OP_W+3:0] ext_acc;
  logic [OP_W+3:0] ext_d;
  logic [OP_W-1:0] acc_next;

  assign bus.char_ready = (state != DONE);
  assign bus.ops_valid  = (state == DONE);
  assign bus.op_a       = acc_a;
  assign bus.op_b       = acc_b;
  assign bus.err        = err_q;

  assign accept   = bus.char_valid & bus.char_ready;
  assign is_digit = (bus.char_in >= 8'h30) && (bus.char_in <= 8'h39);
  assign is_plus  = (bus.char_in == 8'h2B);
  assign is_eq    = (bus.char_in == 8'h3D);

  // For 0x30..0x39 the low nibble equals char - 0x30.
  assign ext_acc  = {4'b0, (state == GET_B) ? acc_b : acc_a};
  assign ext_d    = {{OP_W{1'b0}}, bus.char_in[3:0]};
  assign acc_next = OP_W'((ext_acc << 3) + (ext_acc << 1) + ext_d);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= GET_A;
      acc_a <= '0;
      acc_b <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      acc_a <= acc_a_n;
      acc_b <= acc_b_n;
      cnt   <= cnt_n;
      err_q <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    acc_a_n = acc_a;
    acc_b_n = acc_b;
    cnt_n   = cnt;
    err_n   = 1'b0;
    unique case (state)
      GET_A, GET_B: begin
        if (accept) begin
          unique case (1'b1)
            (is_digit && cnt < DMAX): begin
              if (state == GET_B) acc_b_n = acc_next;
              else                acc_a_n = acc_next;
              cnt_n = cnt + 1'b1;
            end
            (is_plus && cnt != '0 && state == GET_A): begin
              state_n = GET_B;
              cnt_n   = '0;
            end
            (is_eq && cnt != '0 && state == GET_B): begin
              state_n = DONE;
            end
`ifdef ASCII_SPACE_SKIP_EN
            (bus.char_in == 8'h20): begin
            end
`endif
            default: begin
              // Drop the whole expression; offending char is consumed.
              state_n = GET_A;
              acc_a_n = '0;
              acc_b_n = '0;
              cnt_n   = '0;
              err_n   = 1'b1;
            end
          endcase
        end
      end
      DONE: begin
        if (bus.ops_ready) begin
          state_n = GET_A;
          acc_a_n = '0;
          acc_b_n = '0;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = GET_A;
      end
    endcase
  end
endmodule
